// File: rtl/hls_fp17_mul_chn_a_skid_fifo.sv
`default_nettype none
//============================================================================
// Module   : hls_fp17_mul_chn_a_skid_fifo
// Purpose  : Operand buffer in front of the fp17 multiplier core's chn_a
//            wait-control. Accepts operands from the external valid/ready
//            channel, stores them in a small FIFO, and presents them to the
//            core. The core's load strobe has no combinational path to the
//            external ready, so external backpressure is isolated from the
//            core's wait-state timing.
// Ports    : nvdla_core_clk         - core clock, rising edge
//            nvdla_core_rstn        - asynchronous active-low reset
//            chn_a_pvld/prdy/pd     - upstream operand channel (prdy is a flop)
//            chn_a_rsci_vd          - operand available to the core
//            chn_a_rsci_d           - head-of-FIFO operand
//            chn_a_rsci_ld_core_sct - core consumes the head operand
//            chn_a_occ              - current occupancy, 0..DEPTH
//            chn_a_stall_cnt        - stall cycles (only with the macro below)
// Options  : HLS_FP17_CHN_A_STALL_CNT_EN adds a saturating 16-bit counter of
//            cycles where an operand is available but the core does not load.
// Revision : 1.0 - initial release
//============================================================================
module hls_fp17_mul_chn_a_skid_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 2,            // 2, 4 or 8
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             chn_a_pvld,
   output logic             chn_a_prdy,
   input  logic [WIDTH-1:0] chn_a_pd,
   output logic             chn_a_rsci_vd,
   output logic [WIDTH-1:0] chn_a_rsci_d,
   input  logic             chn_a_rsci_ld_core_sct,
   output logic [AW:0]      chn_a_occ
`ifdef HLS_FP17_CHN_A_STALL_CNT_EN
   ,
   output logic [15:0]      chn_a_stall_cnt
`endif
);

   localparam logic [AW-1:0] c_ptr_one = AW'(1);
   localparam logic [AW:0]   c_full    = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_prdy;

   logic             w_vd;
   logic             w_push;
   logic             w_pop;
   logic [AW:0]      w_count_next;

   assign w_vd         = (r_count != '0);
   assign w_push       = chn_a_pvld & r_prdy;
   // A load strobe with nothing buffered is ignored, so the FIFO cannot underflow.
   assign w_pop        = chn_a_rsci_ld_core_sct & w_vd;
   assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

   // Storage: each entry is written only when it is the push target.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
         if (!nvdla_core_rstn) begin
            r_mem[gi] <= '0;
         end else if (w_push && (r_wr_ptr == AW'(gi))) begin
            r_mem[gi] <= chn_a_pd;
         end
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
         r_count <= w_count_next;
      end
   end

   // Ready is registered from next-cycle occupancy: a pop at full reopens
   // the channel on the following cycle, giving at most one bubble.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_prdy <= 1'b0;
      end else begin
         r_prdy <= (w_count_next != c_full);
      end
   end

`ifdef HLS_FP17_CHN_A_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   // A push into an empty FIFO starts a fresh operand, so stall history clears.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_stall_cnt <= '0;
      end else if (w_push && !w_vd) begin
         r_stall_cnt <= '0;
      end else if (w_vd && !chn_a_rsci_ld_core_sct && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign chn_a_stall_cnt = r_stall_cnt;
`endif

   assign chn_a_prdy    = r_prdy;
   assign chn_a_rsci_vd = w_vd;
   assign chn_a_rsci_d  = r_mem[r_rd_ptr];
   assign chn_a_occ     = r_count;

endmodule
`default_nettype wire
